game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_TICKS, default 4, initial number of game ticks a target stays lit (range 1..15).
REQ-002 SHALL have parameter START_LIVES, default 3, lives loaded at game start (range 1..7).
REQ-003 SHALL have parameter SCORE_W, default 8, score counter width.
REQ-004 SHALL have port i_clk  input  1  single clock for all logic.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_tick  input  1  one-cycle game-tick strobe from the clock divider.
REQ-007 SHALL have port i_start  input  1  level; begins a game from IDLE or OVER.
REQ-008 SHALL have port i_rand  input  32  free-running LCG output, sampled only in SPAWN.
REQ-009 SHALL have port i_press_valid  input  1  one-cycle player press strobe.
REQ-010 SHALL have port i_press_pos  input  6  pressed cell, index = x + 8*y.
REQ-011 SHALL have port o_target_valid  output  1  target is lit.
REQ-012 SHALL have port o_target_pos  output  6  lit cell index.
REQ-013 SHALL have port o_target_color  output  2  0 red, 1 green, 2 blue, 3 white.
REQ-014 SHALL have port o_score  output  SCORE_W  hits this game.
REQ-015 SHALL have port o_lives  output  3  remaining lives.
REQ-016 SHALL have port o_hit / o_miss  output  1 each  one-cycle result pulses.
REQ-017 SHALL have port o_game_over  output  1  high while in OVER.
REQ-018 SHALL have port o_state  output  3  IDLE=0, SPAWN=1, SHOW=2, RESULT=3, OVER=4.

Function
REQ-019 SHALL operate an FSM with states IDLE, SPAWN, SHOW, RESULT, OVER; all registers update on rising i_clk.
REQ-020 IDLE or OVER with i_start=1 SHALL load score=0, lives=START_LIVES, window=WINDOW_TICKS, hit_cnt=0, then enter SPAWN next cycle.
REQ-021 SPAWN SHALL last exactly one cycle: pos=i_rand[5:0]; if pos equals previous target pos, use (pos+1) mod 64; color=i_rand[31:30]; timer=window; next state SHOW.
REQ-022 o_target_valid SHALL be 1 exactly while in SHOW; o_target_pos/o_target_color hold their last values in all other states.
REQ-023 In SHOW, i_press_valid with i_press_pos==target pos SHALL produce a hit: score+1 (saturating at all-ones), o_hit=1 for one cycle, next state RESULT.
REQ-024 In SHOW, i_press_valid with a wrong position SHALL produce a miss.
REQ-025 In SHOW, each i_tick SHALL decrement timer; a tick with timer==1 SHALL produce a miss.
REQ-026 Simultaneous correct press and expiring tick SHALL count as a hit only; simultaneous wrong press and tick SHALL count as exactly one miss.
REQ-027 A miss SHALL decrement lives by 1 and pulse o_miss for one cycle; next state OVER if lives becomes 0, else RESULT.
REQ-028 Every hit SHALL increment hit_cnt (2 bits, wrapping); when it wraps to 0, window SHALL decrement by 1, floor 1.
REQ-029 RESULT SHALL wait for the next i_tick, then enter SPAWN the following cycle; presses in RESULT are ignored.
REQ-030 i_start SHALL be ignored in SPAWN, SHOW and RESULT; presses and ticks SHALL be ignored in IDLE and OVER.
REQ-031 o_game_over SHALL be 1 exactly while in OVER; score and lives hold there until restart.
REQ-032 Result pulses (o_hit, o_miss) SHALL never both be 1 in the same cycle.

Reset
REQ-033 i_rst_n=0 SHALL immediately force state IDLE, o_target_valid=0, o_target_pos=0, o_target_color=0, o_score=0, o_lives=0, o_hit=0, o_miss=0, o_game_over=0, window=WINDOW_TICKS, hit_cnt=0, previous pos=0.
REQ-034 Reset asserted mid-SHOW SHALL abort the round with no o_hit/o_miss pulse; after release the block SHALL stay in IDLE until i_start.

Verification
REQ-035 Reset, i_start=1, i_rand=0xC000_0015 -> SPAWN one cycle, then SHOW with pos=21, color=3, lives=3, score=0.
REQ-036 In SHOW at pos 21, press pos 21 -> o_hit one cycle, score=1, RESULT; next i_tick -> SPAWN; i_rand=0x0000_0015 -> pos=22 (repeat avoidance).
REQ-037 No presses, 4 ticks in SHOW (default window) -> o_miss on 4th tick, lives 3->2; three consecutive timeouts -> OVER, o_game_over=1, lives=0; i_start restarts with lives=3, score=0.
REQ-038 Press on correct cell in same cycle as expiring tick -> o_hit only, lives unchanged; wrong press plus tick -> one o_miss, lives decrease by 1.
REQ-039 Eight consecutive hits -> window 4->3->2; twelve more hits -> window holds at 1; with SCORE_W=2, score saturates at 3.
REQ-040 Assert i_rst_n=0 during SHOW -> all outputs reset values same cycle, no pulses; release -> remains IDLE.

Source files
------------

// File: rtl/game_round_ctrl.sv
// Whack-a-target round controller: spawns a lit cell, scores presses, times out on game ticks.
// Pulses o_hit/o_miss are registered; flow is strobe-driven with no backpressure.
module game_round_ctrl #(
  parameter int unsigned WINDOW_TICKS = 4,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic [31:0]        i_rand,
  input  logic               i_press_valid,
  input  logic [5:0]         i_press_pos,
  output logic               o_target_valid,
  output logic [5:0]         o_target_pos,
  output logic [1:0]         o_target_color,
  output logic [SCORE_W-1:0] o_score,
  output logic [2:0]         o_lives,
  output logic               o_hit,
  output logic               o_miss,
  output logic               o_game_over,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPAWN  = 3'd1,
    SHOW   = 3'd2,
    RESULT = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [3:0]         WIN_INIT   = 4'(WINDOW_TICKS);
  localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  state_t               state_q, state_d;
  logic [5:0]           pos_q, pos_d;
  logic [1:0]           color_q, color_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [2:0]           lives_q, lives_d;
  logic [3:0]           window_q, window_d;
  logic [3:0]           timer_q, timer_d;
  logic [1:0]           hit_cnt_q, hit_cnt_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [5:0] spawn_pos;
  logic       press_hit;
  logic       press_miss;
  logic       expire;
  logic       unused_rand;

  assign unused_rand = ^i_rand[29:6];

  // pos_q doubles as the previous target, so a repeated draw steps to the next cell
  assign spawn_pos  = (i_rand[5:0] == pos_q) ? i_rand[5:0] + 6'd1 : i_rand[5:0];
  assign press_hit  = i_press_valid && (i_press_pos == pos_q);
  assign press_miss = i_press_valid && (i_press_pos != pos_q);
  assign expire     = i_tick && (timer_q == 4'd1);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    color_d   = color_q;
    score_d   = score_q;
    lives_d   = lives_q;
    window_d  = window_q;
    timer_d   = timer_q;
    hit_cnt_d = hit_cnt_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (i_start) begin
          score_d   = '0;
          lives_d   = LIVES_INIT;
          window_d  = WIN_INIT;
          hit_cnt_d = 2'd0;
          state_d   = SPAWN;
        end
      end
      SPAWN: begin
        pos_d   = spawn_pos;
        color_d = i_rand[31:30];
        timer_d = window_q;
        state_d = SHOW;
      end
      SHOW: begin
        // a correct press wins over an expiring tick; any miss source counts once
        if (press_hit) begin
          hit_d     = 1'b1;
          score_d   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);
          hit_cnt_d = hit_cnt_q + 2'd1;
          if (hit_cnt_q == 2'd3 && window_q > 4'd1) begin
            window_d = window_q - 4'd1;
          end
          state_d = RESULT;
        end else if (press_miss || expire) begin
          miss_d  = 1'b1;
          lives_d = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
          state_d = (lives_q <= 3'd1) ? OVER : RESULT;
        end else if (i_tick) begin
          timer_d = timer_q - 4'd1;
        end
      end
      RESULT: begin
        if (i_tick) begin
          state_d = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      pos_q     <= 6'd0;
      color_q   <= 2'd0;
      score_q   <= '0;
      lives_q   <= 3'd0;
      window_q  <= WIN_INIT;
      timer_q   <= 4'd0;
      hit_cnt_q <= 2'd0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      color_q   <= color_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      window_q  <= window_d;
      timer_q   <= timer_d;
      hit_cnt_q <= hit_cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign o_target_valid = (state_q == SHOW);
  assign o_target_pos   = pos_q;
  assign o_target_color = color_q;
  assign o_score        = score_q;
  assign o_lives        = lives_q;
  assign o_hit          = hit_q;
  assign o_miss         = miss_q;
  assign o_game_over    = (state_q == OVER);
  assign o_state        = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: expected hit/miss results are queued at stimulus time
// and checked when the DUT pulses; SCORE_W=2 so score saturation is reachable.
module tb_game_round_ctrl;

  localparam int SW   = 2;
  localparam int SMAX = 3;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_tick = 1'b0;
  logic          i_start = 1'b0;
  logic [31:0]   i_rand = 32'd0;
  logic          i_press_valid = 1'b0;
  logic [5:0]    i_press_pos = 6'd0;
  logic          o_target_valid;
  logic [5:0]    o_target_pos;
  logic [1:0]    o_target_color;
  logic [SW-1:0] o_score;
  logic [2:0]    o_lives;
  logic          o_hit;
  logic          o_miss;
  logic          o_game_over;
  logic [2:0]    o_state;

  game_round_ctrl #(.WINDOW_TICKS(4), .START_LIVES(3), .SCORE_W(SW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_start(i_start),
    .i_rand(i_rand), .i_press_valid(i_press_valid), .i_press_pos(i_press_pos),
    .o_target_valid(o_target_valid), .o_target_pos(o_target_pos),
    .o_target_color(o_target_color), .o_score(o_score), .o_lives(o_lives),
    .o_hit(o_hit), .o_miss(o_miss), .o_game_over(o_game_over), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit hit;
    int score;
    int lives;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model
  int m_score, m_lives, m_window, m_hitcnt, m_pos;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_hit || o_miss) begin
      if (sb_q.size() == 0) begin
        chk("unexp_pulse", {30'd0, o_hit, o_miss}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pulse_hit", o_hit, e.hit);
        chk("pulse_miss", o_miss, !e.hit);
        chk("pulse_score", o_score, e.score);
        chk("pulse_lives", o_lives, e.lives);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_game_start();
    m_score = 0; m_lives = 3; m_window = 4; m_hitcnt = 0;
  endtask

  task automatic model_hit();
    exp_t e;
    if (m_score != SMAX) m_score++;
    if (m_hitcnt == 3 && m_window > 1) m_window--;
    m_hitcnt = (m_hitcnt + 1) % 4;
    e.hit = 1'b1; e.score = m_score; e.lives = m_lives;
    sb_q.push_back(e);
  endtask

  task automatic model_miss();
    exp_t e;
    m_lives--;
    e.hit = 1'b0; e.score = m_score; e.lives = m_lives;
    sb_q.push_back(e);
  endtask

  task automatic start_game();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    model_game_start();
    chk("start_state", o_state, 1);
    chk("start_valid", o_target_valid, 0);
  endtask

  task automatic spawn(input logic [31:0] r);
    logic [5:0] p;
    p = r[5:0];
    if (p == m_pos[5:0]) p = p + 6'd1;
    i_rand = r;
    step();
    m_pos = p;
    chk("spawn_state", o_state, 2);
    chk("spawn_valid", o_target_valid, 1);
    chk("spawn_pos", o_target_pos, p);
    chk("spawn_color", o_target_color, r[31:30]);
    chk("spawn_lives", o_lives, m_lives);
    chk("spawn_score", o_score, m_score);
  endtask

  task automatic hit_round();
    i_press_valid = 1'b1;
    i_press_pos = 6'(m_pos);
    model_hit();
    step();
    i_press_valid = 1'b0;
    chk("hit_state", o_state, 3);
  endtask

  // mode 0: pure timeout, 1: correct press with expiring tick, 2: wrong press with expiring tick
  task automatic timeout_round(input int mode);
    for (int k = 1; k <= m_window; k++) begin
      i_tick = 1'b1;
      if (k == m_window) begin
        if (mode == 1) begin
          i_press_valid = 1'b1; i_press_pos = 6'(m_pos); model_hit();
        end else begin
          if (mode == 2) begin
            i_press_valid = 1'b1; i_press_pos = 6'(m_pos + 1);
          end
          model_miss();
        end
      end
      step();
      i_tick = 1'b0;
      i_press_valid = 1'b0;
      if (k < m_window) begin
        chk("tick_state", o_state, 2);
        step();
      end
    end
  endtask

  task automatic finish_result();
    step();
    chk("pulse_len_hit", o_hit, 0);
    chk("pulse_len_miss", o_miss, 0);
    chk("sb_drained", sb_q.size(), 0);
    chk("post_state", o_state, (m_lives == 0) ? 4 : 3);
    chk("game_over", o_game_over, (m_lives == 0) ? 1 : 0);
    if (m_lives != 0) begin
      i_press_valid = 1'b1; i_press_pos = 6'(m_pos);
      step();
      i_press_valid = 1'b0;
      chk("result_wait", o_state, 3);
      i_tick = 1'b1;
      step();
      i_tick = 1'b0;
      chk("result_to_spawn", o_state, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_valid"}, o_target_valid, 0);
    chk({tag, "_pos"}, o_target_pos, 0);
    chk({tag, "_color"}, o_target_color, 0);
    chk({tag, "_score"}, o_score, 0);
    chk({tag, "_lives"}, o_lives, 0);
    chk({tag, "_hit"}, o_hit, 0);
    chk({tag, "_miss"}, o_miss, 0);
    chk({tag, "_over"}, o_game_over, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_pos = 0;
    model_game_start();
    repeat (2) step();
    check_reset_outputs("rst");
    i_rst_n = 1'b1;
    i_tick = 1'b1; i_press_valid = 1'b1;
    step();
    i_tick = 1'b0; i_press_valid = 1'b0;
    chk("idle_ignore", o_state, 0);

    // first round, hit, then repeat-avoiding spawn
    start_game();
    spawn(32'hC000_0015);
    hit_round();
    finish_result();
    spawn(32'h0000_0015);

    // three timeouts end the game
    timeout_round(0); finish_result(); spawn($urandom);
    timeout_round(0); finish_result(); spawn($urandom);
    timeout_round(0); finish_result();
    i_tick = 1'b1; i_press_valid = 1'b1; i_press_pos = 6'(m_pos);
    step();
    i_tick = 1'b0; i_press_valid = 1'b0;
    chk("over_hold_state", o_state, 4);
    chk("over_hold_lives", o_lives, 0);

    // restart, simultaneous press+tick cases
    start_game();
    spawn($urandom);
    timeout_round(1); finish_result(); spawn($urandom);
    timeout_round(2); finish_result(); spawn($urandom);

    // window shrink and score saturation
    for (int i = 0; i < 8; i++) begin
      hit_round(); finish_result(); spawn((i == 3) ? {26'd0, m_pos[5:0]} : $urandom);
    end
    chk("window_after_8", m_window, 2);
    timeout_round(0); finish_result(); spawn($urandom);
    for (int i = 0; i < 12; i++) begin
      hit_round(); finish_result(); spawn($urandom);
    end
    chk("window_floor", m_window, 1);
    chk("score_sat", o_score, SMAX);
    timeout_round(0); finish_result();

    // reset mid-SHOW
    start_game();
    spawn($urandom);
    i_press_valid = 1'b1; i_press_pos = 6'(m_pos);
    #1 i_rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    i_press_valid = 1'b0;
    m_pos = 0;
    repeat (3) step();
    i_rst_n = 1'b1;
    i_tick = 1'b1;
    repeat (3) step();
    i_tick = 1'b0;
    chk("post_rst_state", o_state, 0);
    chk("post_rst_valid", o_target_valid, 0);
    start_game();
    spawn(32'h4000_0000);

    step();
    chk("sb_final", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
